uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter: serialises one word per frame as start, DATA_BITS data bits (LSB first),

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx_frame.sv | 150 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants, FSM state encoding and the baud
//                divider helper used by the transmit and receive framers.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Clocks per bit; a non-positive baud yields 0 so the caller's range check fires.
   function automatic int baud_div(input int clk_hz, input int baud);
      if (baud <= 0) return 0;
      return clk_hz / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter. Counts 0..DIV-1 and wraps; o_tick marks
//                the last clock of each bit period. i_clear holds it at 0.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
   parameter int DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int             CW     = $clog2(DIV);
   localparam logic [CW-1:0]  c_last = CW'(DIV - 1);
   localparam logic [CW-1:0]  c_one  = CW'(1);

   logic [CW-1:0] r_count;

   // Free-running bit-period counter, restarted whenever the framer is idle.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count <= '0;
      end else if (r_count == c_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_one;
      end
   end

   assign o_tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : UART transmitter. Sends start, DATA_BITS data bits LSB first,
//                optional parity and 1 or 2 stop bits, each DIV clocks long,
//                with a valid/ready word handshake. All outputs registered.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_ready,
   output logic                 o_tx,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int            c_div       = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int            BW          = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] c_last_bit  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] c_last_stop = BW'(STOP_BITS - 1);
   localparam logic [BW-1:0] c_one       = BW'(1);

   if (c_div < 2) begin : g_bad_div
      $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be in 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   uart_state_t          r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0]        r_bit_idx;
   logic                 r_parity;
   logic                 w_tick;
   logic                 w_accept;

   assign w_accept = i_valid && o_ready;

   // Bit timing restarts from zero on the accept edge because the counter is held while idle.
   uart_baud_gen #(
      .DIV (c_div)
   ) u_baud_gen (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (r_state == ST_IDLE),
      .o_tick  (w_tick)
   );

   // Frame sequencer: each state advances on a bit-period tick and drives the line for the next bit.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_parity  <= 1'b0;
         o_tx      <= 1'b1;
         o_ready   <= 1'b1;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_shift   <= i_data;
                  // Parity is frozen with the word so later i_data changes cannot affect it.
                  r_parity  <= (PARITY == PARITY_EVEN) ? (^i_data) : (~^i_data);
                  r_bit_idx <= '0;
                  r_state   <= ST_START;
                  o_tx      <= 1'b0;
                  o_ready   <= 1'b0;
                  o_busy    <= 1'b1;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_state   <= ST_DATA;
                  r_bit_idx <= '0;
                  o_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == c_last_bit) begin
                     r_bit_idx <= '0;
                     if (PARITY != PARITY_NONE) begin
                        r_state <= ST_PARITY;
                        o_tx    <= r_parity;
                     end else begin
                        r_state <= ST_STOP;
                        o_tx    <= 1'b1;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + c_one;
                     o_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_state   <= ST_STOP;
                  r_bit_idx <= '0;
                  o_tx      <= 1'b1;
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  if (r_bit_idx == c_last_stop) begin
                     r_state   <= ST_IDLE;
                     r_bit_idx <= '0;
                     o_tx      <= 1'b1;
                     o_ready   <= 1'b1;
                     o_busy    <= 1'b0;
                     o_done    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + c_one;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               o_tx    <= 1'b1;
               o_ready <= 1'b1;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame
//  Description : Self-checking bench for uart_tx_frame. Five configurations
//                (8N1, 8E1, 8O1, 8N2, 5N1) at DIV=10, each compared every
//                cycle against a frame-level line model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_frame;

   localparam int NCFG  = 5;
   localparam int DIVTB = 10;

   function automatic int cfg_db(input int k);
      return (k == 4) ? 5 : 8;
   endfunction
   function automatic int cfg_par(input int k);
      return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
   endfunction
   function automatic int cfg_sb(input int k);
      return (k == 3) ? 2 : 1;
   endfunction
   function automatic int frame_len(input int k);
      return DIVTB * (1 + cfg_db(k) + ((cfg_par(k) != 0) ? 1 : 0) + cfg_sb(k));
   endfunction

   // Line image of one frame: bit n is the level during the n-th bit period.
   function automatic logic [15:0] frame_bits(input int k, input logic [8:0] w);
      logic [15:0] b;
      logic [8:0]  m;
      int          db;
      db = cfg_db(k);
      b  = '1;
      b[0] = 1'b0;
      m  = w & ((9'd1 << db) - 9'd1);
      for (int i = 0; i < db; i++) b[1 + i] = m[i];
      if (cfg_par(k) == 2) b[1 + db] = ^m;
      if (cfg_par(k) == 1) b[1 + db] = ~^m;
      return b;
   endfunction

   logic            clk = 1'b0;
   logic [NCFG-1:0] rst;
   logic [NCFG-1:0] valid;
   logic [8:0]      data [NCFG];
   logic [NCFG-1:0] ready, tx, busy, done;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int DB = cfg_db(g);
      uart_tx_frame #(
         .CLK_FREQ  (1000000),
         .BAUD_RATE (100000),
         .DATA_BITS (DB),
         .PARITY    (cfg_par(g)),
         .STOP_BITS (cfg_sb(g))
      ) u_dut (
         .i_clk   (clk),
         .i_rst   (rst[g]),
         .i_valid (valid[g]),
         .i_data  (data[g][DB-1:0]),
         .o_ready (ready[g]),
         .o_tx    (tx[g]),
         .o_busy  (busy[g]),
         .o_done  (done[g])
      );
   end

   // ---------------- behavioural model ----------------
   logic [15:0] m_bits [NCFG];
   int          m_t    [NCFG];
   bit          m_act  [NCFG];
   bit          m_live [NCFG];

   initial begin
      for (int k = 0; k < NCFG; k++) begin
         m_bits[k] = '1; m_t[k] = 0; m_act[k] = 0; m_live[k] = 0;
      end
   end

   // Model update: a word is taken whenever the model says the line is free.
   always @(posedge clk) begin
      for (int k = 0; k < NCFG; k++) begin
         if (rst[k]) begin
            m_act[k]  <= 1'b0;
            m_live[k] <= 1'b1;
         end else if (m_live[k]) begin
            if ((!m_act[k] || m_t[k] == frame_len(k)) && valid[k]) begin
               m_bits[k] <= frame_bits(k, data[k]);
               m_act[k]  <= 1'b1;
               m_t[k]    <= 0;
            end else if (m_act[k]) begin
               if (m_t[k] == frame_len(k)) m_act[k] <= 1'b0;
               m_t[k] <= m_t[k] + 1;
            end
         end
      end
   end

   // Single compare process: every configuration, every cycle after reset.
   always @(negedge clk) begin
      for (int k = 0; k < NCFG; k++) begin
         if (m_live[k]) begin
            logic [3:0] exp_v;
            logic [3:0] got_v;
            if (!m_act[k])                  exp_v = 4'b1100;
            else if (m_t[k] == frame_len(k)) exp_v = 4'b1101;
            else                            exp_v = {m_bits[k][m_t[k] / DIVTB], 3'b010};
            got_v = {tx[k], ready[k], busy[k], done[k]};
            n_checks++;
            if (got_v !== exp_v) begin
               n_err++;
               $display("FAIL model cfg=%0d t=%0d tx/ready/busy/done got=%b expected=%b",
                        k, m_t[k], got_v, exp_v);
            end
         end
      end
   end

   // ---------------- literal checks and stimulus ----------------
   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic wait_ready(input int k);
      int n;
      n = 0;
      while (!ready[k] && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("ready_timeout", 0, 1);
   endtask

   // Sends one word; returns accept-to-done latency and mid-bit line samples.
   task automatic run_frame(input int k, input logic [8:0] w,
                            output int lat, output logic [15:0] samp);
      wait_ready(k);
      valid[k] = 1'b1;
      data[k]  = w;
      @(negedge clk);
      valid[k] = 1'b0;
      lat  = -1;
      samp = '0;
      for (int o = 0; o < 3000; o++) begin
         if (o % 10 == 5 && o / 10 < 16) samp[o / 10] = tx[k];
         if (done[k]) begin
            lat = o;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Back-to-back random words with i_valid held and i_data changing every cycle.
   task automatic stream(input int k, input int nwords);
      int cnt;
      int cyc;
      cnt = 0;
      cyc = 0;
      valid[k] = 1'b1;
      data[k]  = 9'($urandom);
      while (cnt < nwords && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (done[k]) cnt++;
         if (cnt == nwords) valid[k] = 1'b0;
         data[k] = 9'($urandom);
      end
      valid[k] = 1'b0;
      chk($sformatf("stream_words_cfg%0d", k), cnt, nwords);
   endtask

   initial begin
      int          lat;
      int          hi;
      int          ndone;
      logic [15:0] s;

      rst   = '1;
      valid = '0;
      for (int k = 0; k < NCFG; k++) data[k] = '0;
      repeat (3) @(negedge clk);
      chk("reset_tx",    int'(tx[0]),    1);
      chk("reset_ready", int'(ready[0]), 1);
      chk("reset_busy",  int'(busy[0]),  0);
      chk("reset_done",  int'(done[0]),  0);
      rst = '0;
      @(negedge clk);

      // 8N1 0xA5
      run_frame(0, 9'h0A5, lat, s);
      chk("a5_latency", lat, 100);
      chk("a5_line", int'(s[9:0]), int'(10'b1101001010));

      // parity and short word
      run_frame(1, 9'h007, lat, s);
      chk("even_latency", lat, 110);
      chk("even_parity_bit", int'(s[9]), 1);
      run_frame(2, 9'h007, lat, s);
      chk("odd_latency", lat, 110);
      chk("odd_parity_bit", int'(s[9]), 0);
      run_frame(4, 9'h01F, lat, s);
      chk("db5_latency", lat, 70);
      chk("db5_line", int'(s[6:0]), int'(7'b1111110));

      // two stop bits, i_valid held: 0x00 then 0xFF
      wait_ready(3);
      valid[3] = 1'b1;
      data[3]  = 9'h000;
      @(negedge clk);
      data[3] = 9'h0FF;
      lat = -1;
      hi  = 0;
      for (int o = 0; o < 3000; o++) begin
         if (done[3]) begin
            lat = o;
            break;
         end
         hi = tx[3] ? hi + 1 : 0;
         @(negedge clk);
      end
      chk("stop2_latency", lat, 110);
      chk("stop2_high_run", hi, 20);
      @(negedge clk);
      valid[3] = 1'b0;
      chk("stop2_next_start_tx", int'(tx[3]), 0);
      chk("stop2_next_busy", int'(busy[3]), 1);
      repeat (120) @(negedge clk);

      // reset during data bit 3
      wait_ready(0);
      valid[0] = 1'b1;
      data[0]  = 9'h055;
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (45) @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("midrst_tx",    int'(tx[0]),    1);
      chk("midrst_ready", int'(ready[0]), 1);
      chk("midrst_busy",  int'(busy[0]),  0);
      ndone = 0;
      for (int i = 0; i < 150; i++) begin
         if (done[0]) ndone++;
         @(negedge clk);
      end
      chk("midrst_no_done", ndone, 0);
      run_frame(0, 9'h03C, lat, s);
      chk("after_rst_latency", lat, 100);
      chk("after_rst_line", int'(s[9:0]), int'(10'b1001111000));

      // i_valid/i_data toggling while busy
      for (int f = 0; f < 3; f++) begin
         wait_ready(0);
         valid[0] = 1'b1;
         data[0]  = 9'($urandom);
         @(negedge clk);
         for (int i = 0; i < 150; i++) begin
            valid[0] = 1'($urandom);
            data[0]  = 9'($urandom);
            @(negedge clk);
         end
         valid[0] = 1'b0;
         repeat (110) @(negedge clk);
      end

      // random back-to-back streams on all configurations at once
      fork
         stream(0, 256);
         stream(1, 20);
         stream(2, 20);
         stream(3, 20);
         stream(4, 20);
      join
      repeat (130) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
